// File: rtl/led7seg_74hc595_receiver_pkg.sv
// ---------------------------------------------------------------------------
// led7seg_74hc595_receiver_pkg
//   Shared constants and helpers for the 74HC595 LED7seg link receiver.
//   Frame layout: {seg[7:0], sel[7:0]}. Bit 15 is shifted in first.
//   onehot_to_idx turns the digit-select byte into a valid flag plus a
//   3-bit digit index.
// ---------------------------------------------------------------------------
package led7seg_74hc595_receiver_pkg;

  localparam int         FRAME_BITS = 16;
  localparam int         NUM_DIGITS = 8;
  localparam int         SEG_MSB    = 15;
  localparam int         SEG_LSB    = 8;
  localparam int         SEL_MSB    = 7;
  localparam int         SEL_LSB    = 0;
  localparam logic [7:0] BLANK_SEG  = 8'hFF;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } onehot_res_t;

  // vld only when exactly one select bit is set; sel == 0 is rejected.
  // idx ORs the positions of the set bits, so it is meaningful only when
  // vld is high.
  function automatic onehot_res_t onehot_to_idx(input logic [7:0] sel);
    onehot_res_t res;
    logic [3:0]  ones;
    res.vld = 1'b0;
    res.idx = 3'd0;
    ones    = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) begin
        ones    = ones + 4'd1;
        res.idx = res.idx | 3'(i);
      end else begin
        ones    = ones;
      end
    end
    res.vld = (ones == 4'd1);
    return res;
  endfunction

endpackage

// File: rtl/led7seg_74hc595_receiver_if.sv
// ---------------------------------------------------------------------------
// led7seg_74hc595_receiver_if
//   3-wire 74HC595 display link.
//     sclk : shift clock (data sampled on its rising edge)
//     rclk : storage/latch clock
//     dio  : serial data
//   master = controller side (drives the link), slave = receiver side.
// ---------------------------------------------------------------------------
interface led7seg_74hc595_receiver_if;
  logic sclk;
  logic rclk;
  logic dio;

  modport master (output sclk, output rclk, output dio);
  modport slave  (input  sclk, input  rclk, input  dio);
endinterface

// File: rtl/led7seg_74hc595_receiver_sync_rise_det.sv
// ---------------------------------------------------------------------------
// led7seg_74hc595_receiver_sync_rise_det
//   Brings an asynchronous input into the clk domain through STAGES flops,
//   followed by one history flop.
//   RISE = 1 : o_q is a one-cycle rising-edge pulse (s[last] & ~hist).
//   RISE = 0 : o_q is the synchronised level. It carries the same delay as
//              the edge output, so data stays aligned with its clock edge.
//   Ports: clk, rst (sync, active-high), i_d (async in), o_q (out).
// ---------------------------------------------------------------------------
module led7seg_74hc595_receiver_sync_rise_det #(
  parameter int STAGES = 2,
  parameter bit RISE   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  // Synchroniser chain plus history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_hist <= r_sync[STAGES-1];
    end
  end

  assign o_q = RISE ? (r_sync[STAGES-1] & ~r_hist) : r_sync[STAGES-1];

endmodule

// File: rtl/led7seg_74hc595_receiver.sv
// ---------------------------------------------------------------------------
// led7seg_74hc595_receiver
//   Receive end of the 74HC595 LED7seg link. It deserialises 16-bit frames
//   {seg, sel}, decodes the one-hot digit select and stores each segment
//   byte in an 8-digit shadow register.
//   Ports:
//     clk, rst        system clock, synchronous active-high reset
//     link (slave)    sclk / rclk / dio, asynchronous to clk
//     seg_all         digit n segment byte at [8n+7:8n]
//     frame_vld       1-cycle pulse when a good frame is latched
//     frame_digit     digit index written by the last good frame
//     frame_seg       segment byte of the last good frame
//     err_len         1-cycle pulse when rclk arrives with bit count != 16
//     err_sel         1-cycle pulse when 16 bits arrive but sel is not one-hot
//     frame_cnt       good-frame counter, wraps to 0
// ---------------------------------------------------------------------------
module led7seg_74hc595_receiver
  import led7seg_74hc595_receiver_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_SEG   = BLANK_SEG,
  parameter int         CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  led7seg_74hc595_receiver_if.slave     link,
  output logic [8*NUM_DIGITS-1:0]       seg_all,
  output logic                          frame_vld,
  output logic [2:0]                    frame_digit,
  output logic [7:0]                    frame_seg,
  output logic                          err_len,
  output logic                          err_sel,
  output logic [CNT_W-1:0]              frame_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic [4:0] CNT_MAX  = 5'd31;
  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);

  logic                    w_sclk_rise;
  logic                    w_rclk_rise;
  logic                    w_dio;

  logic [FRAME_BITS-1:0]   r_shreg;
  logic [FRAME_BITS-1:0]   w_shreg_nx;
  logic [4:0]              r_bit_cnt;
  logic [4:0]              w_cnt_nx;
  logic [0:0]              r_state;
  logic [7:0]              w_seg;
  logic [7:0]              w_sel;
  onehot_res_t             w_oh;
  logic                    w_len_ok;

  logic [8*NUM_DIGITS-1:0] r_seg_all;
  logic                    r_frame_vld;
  logic [2:0]              r_frame_digit;
  logic [7:0]              r_frame_seg;
  logic                    r_err_len;
  logic                    r_err_sel;
  logic [CNT_W-1:0]        r_frame_cnt;

  led7seg_74hc595_receiver_sync_rise_det #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_sclk_det (
    .clk (clk), .rst (rst), .i_d (link.sclk), .o_q (w_sclk_rise)
  );
  led7seg_74hc595_receiver_sync_rise_det #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_rclk_det (
    .clk (clk), .rst (rst), .i_d (link.rclk), .o_q (w_rclk_rise)
  );
  led7seg_74hc595_receiver_sync_rise_det #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_dio_sync (
    .clk (clk), .rst (rst), .i_d (link.dio), .o_q (w_dio)
  );

  // Post-shift view of the frame: an rclk edge in the same cycle as the
  // 16th sclk edge must still see all 16 bits.
  always_comb begin
    w_shreg_nx = r_shreg;
    w_cnt_nx   = r_bit_cnt;
    if (w_sclk_rise) begin
      w_shreg_nx = {r_shreg[FRAME_BITS-2:0], w_dio};
      if (r_bit_cnt == CNT_MAX) begin
        w_cnt_nx = CNT_MAX;
      end else begin
        w_cnt_nx = r_bit_cnt + 5'd1;
      end
    end else begin
      w_shreg_nx = r_shreg;
    end
    w_seg    = w_shreg_nx[SEG_MSB:SEG_LSB];
    w_sel    = w_shreg_nx[SEL_MSB:SEL_LSB];
    w_oh     = onehot_to_idx(w_sel);
    // IDLE without a fresh sclk edge means zero bits received
    w_len_ok = ((r_state == ST_SHIFT) || w_sclk_rise) && (w_cnt_nx == CNT_FULL);
  end

  // Shift register, bit counter, FSM and latched outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg       <= '0;
      r_bit_cnt     <= 5'd0;
      r_state       <= ST_IDLE;
      r_seg_all     <= {NUM_DIGITS{RESET_SEG}};
      r_frame_vld   <= 1'b0;
      r_frame_digit <= 3'd0;
      r_frame_seg   <= 8'd0;
      r_err_len     <= 1'b0;
      r_err_sel     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_vld <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_sel   <= 1'b0;
      r_shreg     <= w_shreg_nx;
      if (w_rclk_rise) begin
        r_bit_cnt <= 5'd0;
        r_state   <= ST_IDLE;
        if (!w_len_ok) begin
          r_err_len <= 1'b1;
        end else if (!w_oh.vld) begin
          r_err_sel <= 1'b1;
        end else begin
          r_seg_all[{w_oh.idx, 3'b000} +: 8] <= w_seg;
          r_frame_digit <= w_oh.idx;
          r_frame_seg   <= w_seg;
          r_frame_vld   <= 1'b1;
          r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
        end
      end else begin
        r_bit_cnt <= w_cnt_nx;
        if (w_sclk_rise) begin
          r_state <= ST_SHIFT;
        end else begin
          r_state <= r_state;
        end
      end
    end
  end

  assign seg_all     = r_seg_all;
  assign frame_vld   = r_frame_vld;
  assign frame_digit = r_frame_digit;
  assign frame_seg   = r_frame_seg;
  assign err_len     = r_err_len;
  assign err_sel     = r_err_sel;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_led7seg_74hc595_receiver.sv
// ---------------------------------------------------------------------------
// tb_led7seg_74hc595_receiver
//   Directed bench for the LED7seg link receiver. A second instance with a
//   2-bit frame counter shares the link so that counter wrap can be seen.
// ---------------------------------------------------------------------------
module tb_led7seg_74hc595_receiver;

  logic        clk;
  logic        rst;
  logic [63:0] seg_all, seg_all2;
  logic        frame_vld, frame_vld2;
  logic [2:0]  frame_digit, frame_digit2;
  logic [7:0]  frame_seg, frame_seg2;
  logic        err_len, err_len2;
  logic        err_sel, err_sel2;
  logic [15:0] frame_cnt;
  logic [1:0]  frame_cnt2;

  int n_checks = 0;
  int n_errors = 0;
  int n_vld = 0, n_len = 0, n_sel = 0, n_multi = 0;
  int n_vld2 = 0, n_len2 = 0, n_sel2 = 0;
  int s_vld = 0, s_len = 0, s_sel = 0;

  led7seg_74hc595_receiver_if link_if ();

  led7seg_74hc595_receiver #(.SYNC_STAGES(2), .RESET_SEG(8'hFF), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .link (link_if),
    .seg_all (seg_all), .frame_vld (frame_vld), .frame_digit (frame_digit),
    .frame_seg (frame_seg), .err_len (err_len), .err_sel (err_sel),
    .frame_cnt (frame_cnt)
  );

  led7seg_74hc595_receiver #(.SYNC_STAGES(2), .RESET_SEG(8'hFF), .CNT_W(2)) dut2 (
    .clk (clk), .rst (rst), .link (link_if),
    .seg_all (seg_all2), .frame_vld (frame_vld2), .frame_digit (frame_digit2),
    .frame_seg (frame_seg2), .err_len (err_len2), .err_sel (err_sel2),
    .frame_cnt (frame_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies, sampled on the falling edge
  always @(negedge clk) begin
    n_vld  <= n_vld  + int'(frame_vld);
    n_len  <= n_len  + int'(err_len);
    n_sel  <= n_sel  + int'(err_sel);
    n_vld2 <= n_vld2 + int'(frame_vld2);
    n_len2 <= n_len2 + int'(err_len2);
    n_sel2 <= n_sel2 + int'(err_sel2);
    if ((int'(frame_vld) + int'(err_len) + int'(err_sel)) > 1) n_multi <= n_multi + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of val MSB first; the final rclk either follows or coincides with the last sclk
  task automatic send_bits(input logic [31:0] val, input int nbits, input bit rclk_with_last);
    for (int i = nbits - 1; i >= 0; i--) begin
      link_if.dio = val[i];
      wait_clks(4);
      link_if.sclk = 1'b1;
      if (i == 0 && rclk_with_last) link_if.rclk = 1'b1;
      wait_clks(4);
      link_if.sclk = 1'b0;
      link_if.rclk = 1'b0;
    end
    if (!rclk_with_last) begin
      wait_clks(4);
      link_if.rclk = 1'b1;
      wait_clks(4);
      link_if.rclk = 1'b0;
    end
    wait_clks(4);
  endtask

  task automatic check_pulses(input string tag, input int dv, input int dl, input int ds);
    check_val({tag, "_vld"}, 64'(n_vld - s_vld), 64'(dv));
    check_val({tag, "_len"}, 64'(n_len - s_len), 64'(dl));
    check_val({tag, "_sel"}, 64'(n_sel - s_sel), 64'(ds));
    s_vld = n_vld;
    s_len = n_len;
    s_sel = n_sel;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    wait_clks(1);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_seg_all"}, seg_all, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val({tag, "_cnt"},     64'(frame_cnt), 64'd0);
    check_val({tag, "_digit"},   64'(frame_digit), 64'd0);
    check_val({tag, "_seg"},     64'(frame_seg), 64'd0);
    check_val({tag, "_pulses"},  64'({frame_vld, err_len, err_sel}), 64'd0);
  endtask

  logic [7:0] t2_seg [0:7] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};

  initial begin
    rst = 1'b1;
    link_if.sclk = 1'b0;
    link_if.rclk = 1'b0;
    link_if.dio  = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(2);
    check_reset_state("reset");

    // 1: single good frame to digit 0
    send_bits(32'h0000_C001, 16, 1'b0);
    check_pulses("t1", 1, 0, 0);
    check_val("t1_digit", 64'(frame_digit), 64'd0);
    check_val("t1_seg", 64'(frame_seg), 64'hC0);
    check_val("t1_seg_all", seg_all, 64'hFFFF_FFFF_FFFF_FFC0);
    check_val("t1_cnt", 64'(frame_cnt), 64'd1);

    // 2: fill all eight digits from a clean state
    pulse_rst();
    check_val("t2_rst_cnt", 64'(frame_cnt), 64'd0);
    for (int d = 0; d < 8; d++) begin
      logic [7:0] sel;
      sel = 8'd1 << d;
      send_bits({16'h0000, t2_seg[d], sel}, 16, 1'b0);
      check_val("t2_digit", 64'(frame_digit), 64'(d));
      check_val("t2_seg", 64'(frame_seg), 64'(t2_seg[d]));
    end
    check_pulses("t2", 8, 0, 0);
    check_val("t2_seg_all", seg_all, 64'h80F8_8292_99B0_A4F9);
    check_val("t2_cnt", 64'(frame_cnt), 64'd8);

    // 3: short and long frames rejected, then a good one accepted
    send_bits(32'h0000_7FFF, 15, 1'b0);
    check_pulses("t3_15b", 0, 1, 0);
    check_val("t3_15b_seg_all", seg_all, 64'h80F8_8292_99B0_A4F9);
    send_bits(32'h000F_FFFF, 20, 1'b0);
    check_pulses("t3_20b", 0, 1, 0);
    check_val("t3_20b_seg_all", seg_all, 64'h80F8_8292_99B0_A4F9);
    check_val("t3_err_cnt", 64'(frame_cnt), 64'd8);
    send_bits(32'h0000_9904, 16, 1'b0);
    check_pulses("t3_good", 1, 0, 0);
    check_val("t3_digit", 64'(frame_digit), 64'd2);
    check_val("t3_seg_all", seg_all, 64'h80F8_8292_9999_A4F9);
    check_val("t3_cnt", 64'(frame_cnt), 64'd9);

    // 4: select bytes that are not one-hot
    send_bits(32'h0000_5503, 16, 1'b0);
    check_pulses("t4_03", 0, 0, 1);
    send_bits(32'h0000_5500, 16, 1'b0);
    check_pulses("t4_00", 0, 0, 1);
    check_val("t4_seg_all", seg_all, 64'h80F8_8292_9999_A4F9);
    check_val("t4_cnt", 64'(frame_cnt), 64'd9);

    // 5: rclk rises together with the 16th sclk
    send_bits(32'h0000_8E10, 16, 1'b1);
    check_pulses("t5", 1, 0, 0);
    check_val("t5_digit", 64'(frame_digit), 64'd4);
    check_val("t5_seg", 64'(frame_seg), 64'h8E);
    check_val("t5_seg_all", seg_all, 64'h80F8_828E_9999_A4F9);
    check_val("t5_cnt", 64'(frame_cnt), 64'd10);

    // 6: reset mid-frame, then good frames and narrow counter wrap
    for (int i = 7; i >= 0; i--) begin
      link_if.dio = i[0];
      wait_clks(4);
      link_if.sclk = 1'b1;
      wait_clks(4);
      link_if.sclk = 1'b0;
    end
    pulse_rst();
    check_reset_state("t6_rst");
    check_val("t6_rst_cnt2", 64'(frame_cnt2), 64'd0);
    send_bits(32'h0000_A480, 16, 1'b0);
    check_pulses("t6_first", 1, 0, 0);
    check_val("t6_seg_all", seg_all, 64'hA4FF_FFFF_FFFF_FFFF);
    check_val("t6_cnt", 64'(frame_cnt), 64'd1);
    check_val("t6_cnt2", 64'(frame_cnt2), 64'd1);
    send_bits(32'h0000_C001, 16, 1'b0);
    send_bits(32'h0000_F902, 16, 1'b0);
    send_bits(32'h0000_A404, 16, 1'b0);
    check_pulses("t6_more", 3, 0, 0);
    check_val("t6_cnt4", 64'(frame_cnt), 64'd4);
    check_val("t6_cnt2_wrap", 64'(frame_cnt2), 64'd0);
    check_val("t6_seg_all2", seg_all2, 64'hA4FF_FFFF_FFA4_F9C0);
    check_val("t6_digit2", 64'(frame_digit2), 64'd2);
    check_val("t6_seg2", 64'(frame_seg2), 64'hA4);

    // Totals across the run: 15 good frames, 2 length errors, 2 select errors
    check_val("tot_vld2", 64'(n_vld2), 64'd15);
    check_val("tot_len2", 64'(n_len2), 64'd2);
    check_val("tot_sel2", 64'(n_sel2), 64'd2);
    check_val("exclusive", 64'(n_multi), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
